regfile_wport_arbiter: RTL and testbench
========================================

// Module: regfile_wport_arbiter
// PURPOSE
//   Shares the single regfile write port (we/waddr/wdata) between two writers.
//   Writer A: main pipeline writeback. It has fixed priority and no backpressure.
//   Writer B: multi-cycle unit (div/mem), valid/ready handshake.
//   Sits between the WB stage, the multi-cycle unit and regfile.
//   Raises a registered stall request to the pipeline when B has starved MAX_WAIT cycles.
// PARAMETERS
//   MAX_WAIT  4  cycles B may be blocked before stall_req asserts (>=1)
//   CNT_W     3  width of wait counter; must hold MAX_WAIT
// PORTS
//   clk          in   1   clock; all state on posedge
//   rst          in   1   synchronous, active-high reset (`RstEnable)
//   a_we         in   1   pipeline write request
//   a_waddr      in   5   pipeline dest reg (`RegAddrBus)
//   a_wdata      in   32  pipeline result (`RegBus)
//   b_valid      in   1   multi-cycle unit result valid
//   b_waddr      in   5   multi-cycle dest reg
//   b_wdata      in   32  multi-cycle result
//   b_ready      out  1   B result accepted this cycle (combinational)
//   we           out  1   to regfile write enable
//   waddr        out  5   to regfile write address
//   wdata        out  32  to regfile write data
//   stall_req    out  1   registered; pipeline must hold, a_we=0 next cycle
//   b_pend       out  1   B waiting (b_valid & ~b_ready), for ID hazard check
// BEHAVIOUR
//   Reset: state=IDLE, wait_cnt=0, stall_req=0. Comb outputs while rst=1:
//     we=0, waddr=0, wdata=`ZeroWord, b_ready=0.
//   a_act = a_we & (a_waddr != `NOPRegAddr).
//   Grant each cycle (comb, zero latency, so regfile bypass sees it same cycle):
//     a_act                       -> we=1, waddr/wdata=A, b_ready=(b_valid & b_waddr==0)
//     ~a_act & b_valid            -> we=(b_waddr!=0), waddr/wdata=B, b_ready=1
//     else                        -> we=0, waddr=0, wdata=`ZeroWord, b_ready=0
//   A writes to $0 are dropped and never block B.
//   B writes to $0 are consumed without using the port, even when A is active.
//   FSM (registered):
//     IDLE : b_valid & ~b_ready -> WAIT, wait_cnt=1; else stay.
//     WAIT : b_ready -> IDLE, cnt=0.
//            ~b_valid (protocol violation) -> IDLE, cnt=0.
//            otherwise cnt++; when cnt reaches MAX_WAIT -> STALL.
//     STALL: stall_req=1 while in STALL.
//            b_ready -> IDLE, stall_req=0 next cycle.
//            ~b_valid -> IDLE.
//   stall_req is 1 exactly in STALL (registered Moore output).
//   The pipeline honours it by driving a_we=0 the following cycle, so B wins within 1 cycle.
//   If A still writes during STALL: A keeps priority and the FSM stays in STALL (no deadlock, no loss).
//   MAX_WAIT=1: first blocked cycle moves straight to STALL.
//   Same-address A/B collision: A written first, B one cycle later.
//     Ordering of WAW hazards is an ID-stage concern; b_pend/b_waddr exported for it.
//   Sync reset in WAIT/STALL: returns to IDLE next edge; B must re-present.
//   Counter saturates at MAX_WAIT; never wraps.
// STRUCTURE
//   Shared defines: reuse `RegAddrBus, `RegBus, `NOPRegAddr, `ZeroWord, `RstEnable, `WriteEnable.
//   Add to defines: `ArbIdle 2'b00, `ArbWait 2'b01, `ArbStall 2'b10.
//   Single module, no sub-module. Grant mux is comb; FSM plus counter in one always @(posedge clk).
// TESTING
//   1 rst=1 with all inputs active -> we=0, b_ready=0, stall_req=0. After release: IDLE.
//   2 a_we=1 a_waddr=5 a_wdata=0x11, b idle -> we=1 waddr=5 wdata=0x11 same cycle.
//   3 b_valid waddr=7 data=0xAB, a_we=0 -> b_ready=1, we=1 waddr=7, same cycle.
//   4 A writes r3 every cycle, b_valid r8, MAX_WAIT=4 -> b_ready=0 for 4 cycles, stall_req=1 on 5th;
//     then drop a_we -> r8 written, b_ready=1, stall_req=0 next cycle.
//   5 a_we r0 + b_valid r9 -> B granted, we=1 waddr=9.
//     a_we r4 + b_valid r0 -> waddr=4 and b_ready=1 together.
//   6 Reset asserted in STALL -> stall_req=0 next cycle, cnt=0.
//     b_valid drops in WAIT -> IDLE, b_pend=0.

Source files
------------

// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared widths, constants and FSM encoding for the regfile write-port arbiter.
// Imported by regfile_wport_arbiter; no ports.
package regfile_wport_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_W      = 32;

    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;
    localparam logic [REG_W-1:0]      ZERO_WORD    = '0;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_WAIT  = 2'b01,
        ARB_STALL = 2'b10
    } arb_state_e;

endpackage

// File: rtl/regfile_wport_arbiter.sv
// Shares the single regfile write port between pipeline writeback (A, fixed
// priority, no backpressure) and a multi-cycle unit (B, valid/ready).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   a_we/a_waddr/a_wdata     pipeline writeback request
//   b_valid/b_waddr/b_wdata  multi-cycle result, b_ready = accepted (comb)
//   we/waddr/wdata           regfile write port (comb, zero latency)
//   stall_req                registered; B has been starved MAX_WAIT cycles
//   b_pend                   B presented but not accepted this cycle
module regfile_wport_arbiter
    import regfile_wport_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_we,
    input  logic [REG_ADDR_W-1:0] a_waddr,
    input  logic [REG_W-1:0]      a_wdata,
    input  logic                  b_valid,
    input  logic [REG_ADDR_W-1:0] b_waddr,
    input  logic [REG_W-1:0]      b_wdata,
    output logic                  b_ready,
    output logic                  we,
    output logic [REG_ADDR_W-1:0] waddr,
    output logic [REG_W-1:0]      wdata,
    output logic                  stall_req,
    output logic                  b_pend
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    arb_state_e       r_state;
    arb_state_e       w_nxt_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nxt_cnt;

    logic w_a_act;
    logic w_b_zero;
    logic w_blocked;

    // A writes to $0 are no-ops and must not steal the port from B.
    assign w_a_act  = a_we & (a_waddr != NOP_REG_ADDR);
    assign w_b_zero = (b_waddr == NOP_REG_ADDR);

    always_comb begin
        we      = 1'b0;
        waddr   = NOP_REG_ADDR;
        wdata   = ZERO_WORD;
        b_ready = 1'b0;
        if (!rst) begin
            if (w_a_act) begin
                we      = 1'b1;
                waddr   = a_waddr;
                wdata   = a_wdata;
                // B to $0 needs no port, so it can retire alongside A.
                b_ready = b_valid & w_b_zero;
            end else if (b_valid) begin
                we      = ~w_b_zero;
                waddr   = b_waddr;
                wdata   = b_wdata;
                b_ready = 1'b1;
            end
        end
    end

    assign w_blocked = b_valid & ~b_ready;
    assign b_pend    = w_blocked;
    assign stall_req = (r_state == ARB_STALL);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_blocked) begin
                    w_nxt_cnt   = ONE;
                    w_nxt_state = (MAX_WAIT <= 1) ? ARB_STALL : ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (!w_blocked) begin
                    w_nxt_state = ARB_IDLE;
                    w_nxt_cnt   = '0;
                end else if (r_cnt >= MAX_CNT - ONE) begin
                    // Saturate at MAX_WAIT; the count never wraps.
                    w_nxt_state = ARB_STALL;
                    w_nxt_cnt   = MAX_CNT;
                end else begin
                    w_nxt_cnt = r_cnt + ONE;
                end
            end
            ARB_STALL: begin
                // A may still win here; hold the stall until B retires or leaves.
                if (!w_blocked) begin
                    w_nxt_state = ARB_IDLE;
                    w_nxt_cnt   = '0;
                end
            end
            default: begin
                w_nxt_state = ARB_IDLE;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
        end
    end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Bench for regfile_wport_arbiter: directed steps then random traffic, two
// instances (MAX_WAIT=4 and MAX_WAIT=1) checked against a starvation-streak model.
module tb_regfile_wport_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, a_we, b_valid;
    logic [4:0]  a_waddr, b_waddr;
    logic [31:0] a_wdata, b_wdata;

    logic        b_ready0, we0, stall0, pend0;
    logic [4:0]  waddr0;
    logic [31:0] wdata0;
    logic        b_ready1, we1, stall1, pend1;
    logic [4:0]  waddr1;
    logic [31:0] wdata1;

    regfile_wport_arbiter #(.MAX_WAIT(4), .CNT_W(3)) dut0 (
        .clk(clk), .rst(rst),
        .a_we(a_we), .a_waddr(a_waddr), .a_wdata(a_wdata),
        .b_valid(b_valid), .b_waddr(b_waddr), .b_wdata(b_wdata),
        .b_ready(b_ready0), .we(we0), .waddr(waddr0), .wdata(wdata0),
        .stall_req(stall0), .b_pend(pend0)
    );

    regfile_wport_arbiter #(.MAX_WAIT(1), .CNT_W(3)) dut1 (
        .clk(clk), .rst(rst),
        .a_we(a_we), .a_waddr(a_waddr), .a_wdata(a_wdata),
        .b_valid(b_valid), .b_waddr(b_waddr), .b_wdata(b_wdata),
        .b_ready(b_ready1), .we(we1), .waddr(waddr1), .wdata(wdata1),
        .stall_req(stall1), .b_pend(pend1)
    );

    int errors = 0;
    int checks = 0;
    // Consecutive cycles each instance has left B starving.
    int streak0 = 0;
    int streak1 = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic aw, input logic [4:0] aa,
                       input logic [31:0] ad, input logic bv,
                       input logic [4:0] ba, input logic [31:0] bd);
        logic        e_we, e_rdy;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        @(negedge clk);
        rst = r; a_we = aw; a_waddr = aa; a_wdata = ad;
        b_valid = bv; b_waddr = ba; b_wdata = bd;
        #1;
        e_we = 1'b0; e_rdy = 1'b0; e_addr = 5'd0; e_data = 32'd0;
        if (!r) begin
            if (aw && aa != 5'd0) begin
                e_we = 1'b1; e_addr = aa; e_data = ad;
                e_rdy = bv && (ba == 5'd0);
            end else if (bv) begin
                e_we = (ba != 5'd0); e_addr = ba; e_data = bd;
                e_rdy = 1'b1;
            end
        end
        chk("we0", {31'd0, we0}, {31'd0, e_we});
        chk("waddr0", {27'd0, waddr0}, {27'd0, e_addr});
        chk("wdata0", wdata0, e_data);
        chk("b_ready0", {31'd0, b_ready0}, {31'd0, e_rdy});
        chk("b_pend0", {31'd0, pend0}, {31'd0, bv & ~e_rdy});
        chk("stall0", {31'd0, stall0}, {31'd0, streak0 >= 4});
        chk("we1", {31'd0, we1}, {31'd0, e_we});
        chk("waddr1", {27'd0, waddr1}, {27'd0, e_addr});
        chk("b_ready1", {31'd0, b_ready1}, {31'd0, e_rdy});
        chk("stall1", {31'd0, stall1}, {31'd0, streak1 >= 1});
        if (r || !(bv && !e_rdy)) begin
            streak0 = 0;
            streak1 = 0;
        end else begin
            if (streak0 < 100) streak0++;
            if (streak1 < 100) streak1++;
        end
    endtask

    initial begin
        rst = 1'b1; a_we = 1'b1; a_waddr = 5'd3; a_wdata = 32'h1;
        b_valid = 1'b1; b_waddr = 5'd4; b_wdata = 32'h2;
        @(posedge clk);
        @(posedge clk);
        // 1: reset with all inputs active
        cyc(1, 1, 5'd3, 32'h1, 1, 5'd4, 32'h2);
        cyc(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        // 2: A alone
        cyc(0, 1, 5'd5, 32'h11, 0, 5'd0, 32'h0);
        // 3: B alone
        cyc(0, 0, 5'd0, 32'h0, 1, 5'd7, 32'hAB);
        // 4: A hogs the port until stall, then yields
        for (int i = 0; i < 5; i++)
            cyc(0, 1, 5'd3, 32'h30 + i, 1, 5'd8, 32'h88);
        chk("stall_on5", {31'd0, stall0}, 32'd1);
        cyc(0, 0, 5'd0, 32'h0, 1, 5'd8, 32'h88);
        cyc(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        chk("stall_clear", {31'd0, stall0}, 32'd0);
        // 5: A to $0 never blocks; B to $0 retires beside A
        cyc(0, 1, 5'd0, 32'h5, 1, 5'd9, 32'h99);
        cyc(0, 1, 5'd4, 32'h44, 1, 5'd0, 32'h77);
        // A keeps priority during STALL without deadlock
        for (int i = 0; i < 7; i++)
            cyc(0, 1, 5'd6, 32'h60, 1, 5'd10, 32'hA0);
        // 6: reset while in STALL
        cyc(1, 1, 5'd6, 32'h60, 1, 5'd10, 32'hA0);
        cyc(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        // b_valid drops while waiting
        cyc(0, 1, 5'd2, 32'h2, 1, 5'd11, 32'hB);
        cyc(0, 1, 5'd2, 32'h2, 1, 5'd11, 32'hB);
        cyc(0, 1, 5'd2, 32'h2, 0, 5'd11, 32'hB);
        cyc(0, 1, 5'd2, 32'h2, 0, 5'd0, 32'h0);
        // random traffic; pipeline usually honours stall_req
        for (int i = 0; i < 600; i++) begin
            logic        r, aw, bv;
            logic [4:0]  aa, ba;
            r  = ($urandom_range(0, 49) == 0);
            aw = ($urandom_range(0, 9) < 8);
            if (streak0 >= 4 && $urandom_range(0, 9) < 6) aw = 1'b0;
            bv = ($urandom_range(0, 9) < 6);
            aa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            ba = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            cyc(r, aw, aa, $urandom, bv, ba, $urandom);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
